// File: rtl/dcache_mem_subsystem.sv
// Direct-mapped write-back/write-allocate data cache (8 x 4-byte blocks) in front of a
// 64-word backing memory with a fixed multi-cycle latency.
module dcache_mem_subsystem #(
  parameter int MEM_LATENCY = 5
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       READ,
  input  logic       WRITE,
  input  logic [7:0] ADDRESS,
  input  logic [7:0] WRITE_DATA,
  output logic [7:0] READ_DATA,
  output logic       BUSYWAIT
);

  localparam int CW = $clog2(MEM_LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WRITE_BACK   = 2'd1,
    MEM_READ     = 2'd2,
    CACHE_UPDATE = 2'd3
  } state_t;

  state_t      state_r, state_next_s;
  logic [7:0]  valid_r, dirty_r;
  logic [2:0]  tag_r   [8];
  logic [31:0] block_r [8];
  logic [31:0] fill_r;
  logic [31:0] mem_r   [64];
  logic [CW-1:0] cnt_r, cnt_inc_s;
  logic        ack_r;

  logic [2:0]  tag_s, index_s;
  logic [1:0]  offset_s;
  logic        req_s, hit_s;
  logic        mem_read_s, mem_write_s, mem_req_s;
  logic [5:0]  mem_addr_s;
  logic [31:0] mem_wdata_s, mem_rdata_s;

  function automatic logic [7:0] get_byte(input logic [31:0] blk, input logic [1:0] off);
    return blk[{off, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] put_byte(input logic [31:0] blk, input logic [1:0] off,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = blk;
    r[{off, 3'b000} +: 8] = b;
    return r;
  endfunction

  assign tag_s       = ADDRESS[7:5];
  assign index_s     = ADDRESS[4:2];
  assign offset_s    = ADDRESS[1:0];
  assign req_s       = READ | WRITE;
  assign hit_s       = valid_r[index_s] && (tag_r[index_s] == tag_s);
  assign mem_req_s   = mem_read_s | mem_write_s;
  assign mem_rdata_s = mem_r[mem_addr_s];
  assign cnt_inc_s   = cnt_r + {{(CW-1){1'b0}}, 1'b1};
  assign BUSYWAIT    = req_s && !((state_r == IDLE) && hit_s);

  // Load data path; a simultaneous READ+WRITE is a store and returns zero
  always_comb begin
    READ_DATA = 8'd0;
    if (READ && !WRITE && hit_s && (state_r == IDLE)) begin
      READ_DATA = get_byte(block_r[index_s], offset_s);
    end else begin
      READ_DATA = 8'd0;
    end
  end

  // Cache controller next state and memory request generation
  always_comb begin
    state_next_s = state_r;
    mem_read_s   = 1'b0;
    mem_write_s  = 1'b0;
    mem_addr_s   = ADDRESS[7:2];
    mem_wdata_s  = 32'd0;
    case (state_r)
      IDLE: begin
        if (req_s && !hit_s) begin
          if (valid_r[index_s] && dirty_r[index_s]) begin
            state_next_s = WRITE_BACK;
          end else begin
            state_next_s = MEM_READ;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      WRITE_BACK: begin
        mem_write_s = 1'b1;
        mem_addr_s  = {tag_r[index_s], index_s};
        mem_wdata_s = block_r[index_s];
        // ack_r low-to-high is exactly when the memory drops its busywait
        if (ack_r) begin
          state_next_s = MEM_READ;
        end else begin
          state_next_s = WRITE_BACK;
        end
      end
      MEM_READ: begin
        mem_read_s = 1'b1;
        if (ack_r) begin
          state_next_s = CACHE_UPDATE;
        end else begin
          state_next_s = MEM_READ;
        end
      end
      CACHE_UPDATE: begin
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Cache state: FSM register, tag/valid/dirty arrays, data blocks and fill latch
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_r <= IDLE;
      valid_r <= 8'd0;
      dirty_r <= 8'd0;
      fill_r  <= 32'd0;
      for (int i = 0; i < 8; i++) begin
        tag_r[i]   <= 3'd0;
        block_r[i] <= 32'd0;
      end
    end else begin
      state_r <= state_next_s;
      case (state_r)
        IDLE: begin
          if (WRITE && hit_s) begin
            block_r[index_s] <= put_byte(block_r[index_s], offset_s, WRITE_DATA);
            dirty_r[index_s] <= 1'b1;
          end
        end
        MEM_READ: begin
          if (ack_r) begin
            fill_r <= mem_rdata_s;
          end
        end
        CACHE_UPDATE: begin
          block_r[index_s] <= fill_r;
          tag_r[index_s]   <= tag_s;
          valid_r[index_s] <= 1'b1;
          dirty_r[index_s] <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  // Backing memory: latency counter, one-cycle ack, write commit on the ack edge
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      cnt_r <= {CW{1'b0}};
      ack_r <= 1'b0;
      for (int i = 0; i < 64; i++) begin
        mem_r[i] <= 32'd0;
      end
    end else if (mem_req_s) begin
      if (ack_r) begin
        cnt_r <= {CW{1'b0}};
        ack_r <= 1'b0;
        if (mem_write_s) begin
          mem_r[mem_addr_s] <= mem_wdata_s;
        end
      end else begin
        cnt_r <= cnt_inc_s;
        ack_r <= (cnt_inc_s == CW'(MEM_LATENCY));
      end
    end else begin
      cnt_r <= {CW{1'b0}};
      ack_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dcache_mem_subsystem.sv
// Directed bench for dcache_mem_subsystem: stall counts, load data and internal cache/memory state.
module tb_dcache_mem_subsystem;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       READ;
  logic       WRITE;
  logic [7:0] ADDRESS;
  logic [7:0] WRITE_DATA;
  logic [7:0] READ_DATA;
  logic       BUSYWAIT;

  int errors = 0;
  int checks = 0;
  int stalls;
  logic [7:0] rdata;
  logic [1:0] st;

  dcache_mem_subsystem #(.MEM_LATENCY(5)) dut (
    .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE), .ADDRESS(ADDRESS),
    .WRITE_DATA(WRITE_DATA), .READ_DATA(READ_DATA), .BUSYWAIT(BUSYWAIT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents a request just after an edge, counts stalled cycles, captures load data at completion.
  task automatic do_req(input logic r, input logic w, input logic [7:0] a, input logic [7:0] d,
                        output int n, output logic [7:0] q);
    READ = r; WRITE = w; ADDRESS = a; WRITE_DATA = d;
    n = 0;
    @(negedge CLK);
    while (BUSYWAIT && n < 100) begin
      n++;
      @(negedge CLK);
    end
    q = READ_DATA;
    @(posedge CLK);
    #1;
    READ = 1'b0; WRITE = 1'b0;
  endtask

  initial begin
    RESET = 1'b0; READ = 1'b0; WRITE = 1'b0; ADDRESS = 8'd0; WRITE_DATA = 8'd0;
    repeat (2) @(posedge CLK);
    #1;
    st = dut.state_r;
    chk("rst_state", 32'(st), 32'd0);
    chk("rst_valid", 32'(dut.valid_r), 32'd0);
    chk("rst_busy", 32'(BUSYWAIT), 32'd0);
    chk("rst_rdata", 32'(READ_DATA), 32'd0);
    RESET = 1'b1;
    @(posedge CLK); #1;

    // clean miss
    do_req(1'b1, 1'b0, 8'h05, 8'h00, stalls, rdata);
    chk("clean_miss_stalls", 32'(stalls), 32'd8);
    chk("clean_miss_rdata", 32'(rdata), 32'h00);
    chk("e1_valid", 32'(dut.valid_r[1]), 32'd1);
    chk("e1_clean", 32'(dut.dirty_r[1]), 32'd0);
    chk("e1_tag0", 32'(dut.tag_r[1]), 32'd0);

    // write hit then read hit
    do_req(1'b0, 1'b1, 8'h05, 8'hAB, stalls, rdata);
    chk("write_hit_stalls", 32'(stalls), 32'd0);
    do_req(1'b1, 1'b0, 8'h05, 8'h00, stalls, rdata);
    chk("read_hit_stalls", 32'(stalls), 32'd0);
    chk("read_hit_rdata", 32'(rdata), 32'hAB);
    chk("e1_dirty", 32'(dut.dirty_r[1]), 32'd1);

    // dirty miss on same index
    do_req(1'b1, 1'b0, 8'h25, 8'h00, stalls, rdata);
    chk("dirty_miss_stalls", 32'(stalls), 32'd14);
    chk("wb_mem1", dut.mem_r[1], 32'h0000AB00);
    chk("dirty_miss_rdata", 32'(rdata), 32'h00);
    chk("e1_clean_after", 32'(dut.dirty_r[1]), 32'd0);
    chk("e1_tag1", 32'(dut.tag_r[1]), 32'd1);

    // byte packing through eviction
    do_req(1'b0, 1'b1, 8'h10, 8'h11, stalls, rdata);
    chk("wr10_stalls", 32'(stalls), 32'd8);
    do_req(1'b0, 1'b1, 8'h11, 8'h22, stalls, rdata);
    do_req(1'b0, 1'b1, 8'h12, 8'h33, stalls, rdata);
    do_req(1'b0, 1'b1, 8'h13, 8'h44, stalls, rdata);
    chk("wr13_stalls", 32'(stalls), 32'd0);
    do_req(1'b1, 1'b0, 8'h30, 8'h00, stalls, rdata);
    chk("evict4_stalls", 32'(stalls), 32'd14);
    chk("wb_mem4", dut.mem_r[4], 32'h44332211);

    // reset during MEM_READ
    READ = 1'b1; ADDRESS = 8'h44;
    @(posedge CLK); @(posedge CLK); #1;
    st = dut.state_r;
    chk("in_mem_read", 32'(st), 32'd2);
    RESET = 1'b0; READ = 1'b0;
    @(posedge CLK); #1;
    st = dut.state_r;
    chk("midrst_state", 32'(st), 32'd0);
    chk("midrst_valid", 32'(dut.valid_r), 32'd0);
    chk("midrst_mem4", dut.mem_r[4], 32'd0);
    RESET = 1'b1;
    @(posedge CLK); #1;
    do_req(1'b1, 1'b0, 8'h44, 8'h00, stalls, rdata);
    chk("reissue_stalls", 32'(stalls), 32'd8);
    chk("reissue_rdata", 32'(rdata), 32'h00);

    // READ and WRITE together act as a store
    do_req(1'b1, 1'b1, 8'h08, 8'h5A, stalls, rdata);
    chk("rw_stalls", 32'(stalls), 32'd8);
    chk("rw_rdata", 32'(rdata), 32'h00);
    chk("e2_dirty", 32'(dut.dirty_r[2]), 32'd1);
    do_req(1'b1, 1'b0, 8'h08, 8'h00, stalls, rdata);
    chk("rw_readback_stalls", 32'(stalls), 32'd0);
    chk("rw_readback", 32'(rdata), 32'h5A);

    // index wrap: 0x00 and 0x20 evict each other
    do_req(1'b1, 1'b0, 8'h00, 8'h00, stalls, rdata);
    chk("wrap_a_stalls", 32'(stalls), 32'd8);
    do_req(1'b1, 1'b0, 8'h20, 8'h00, stalls, rdata);
    chk("wrap_b_stalls", 32'(stalls), 32'd8);
    chk("wrap_tag", 32'(dut.tag_r[0]), 32'd1);
    do_req(1'b1, 1'b0, 8'h00, 8'h00, stalls, rdata);
    chk("wrap_a_again", 32'(stalls), 32'd8);

    @(negedge CLK);
    chk("idle_busy", 32'(BUSYWAIT), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
